// File: rtl/gp_regs_pkg.sv
// Shared constants and bit-manipulation helpers for the multi-port register file.
package gp_regs_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_IDX_W  = 4;
  localparam int DEF_LANE_W = 16;

  // Working widths for the generic helpers; callers size-cast results down.
  localparam int MAX_W   = 256;
  localparam int MAX_LW  = 8;
  localparam int MAX_BUS = 1024;

  // Expand per-lane strobes into a per-bit mask (bit i follows strobe i/lane_w).
  function automatic logic [MAX_W-1:0] lane_mask(input logic [MAX_W-1:0] lanes,
                                                 input int lane_w);
    logic [MAX_W-1:0] m;
    m = '0;
    for (int i = 0; i < MAX_W; i++) begin
      m[MAX_LW'(i)] = lanes[MAX_LW'(i / lane_w)];
    end
    return m;
  endfunction

  // Slice p of width w from a packed bus; only the low w bits are meaningful.
  function automatic logic [MAX_W-1:0] get_slice(input logic [MAX_BUS-1:0] bus,
                                                 input int p, input int w);
    return MAX_W'(bus >> (p * w));
  endfunction

endpackage

// File: rtl/gp_regs_wmerge.sv
// Combinational merge of all write ports into one register's next value.
// Later ports override earlier ones lane by lane; unstrobed lanes keep old_val.
module gp_regs_wmerge
  import gp_regs_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int IDX_W  = DEF_IDX_W,
  parameter int NUM_WR = 2,
  parameter int LANE_W = DEF_LANE_W,
  localparam int NL    = DATA_W / LANE_W
) (
  input  logic [IDX_W-1:0]         idx,
  input  logic [DATA_W-1:0]        old_val,
  input  logic [NUM_WR-1:0]        wr_en,
  input  logic [NUM_WR*IDX_W-1:0]  wr_idx,
  input  logic [NUM_WR*DATA_W-1:0] wr_data,
  input  logic [NUM_WR*NL-1:0]     wr_lane,
  output logic [DATA_W-1:0]        new_val
);

  always_comb begin
    logic [IDX_W-1:0]  widx;
    logic [DATA_W-1:0] wdat;
    logic [DATA_W-1:0] mask;
    // NOTE: blocking assignments here so each port builds on the previous
    // port's result within one evaluation; that ordering is the priority.
    new_val = old_val;
    widx    = '0;
    wdat    = '0;
    mask    = '0;
    for (int p = 0; p < NUM_WR; p++) begin
      widx = IDX_W'(get_slice(MAX_BUS'(wr_idx), p, IDX_W));
      wdat = DATA_W'(get_slice(MAX_BUS'(wr_data), p, DATA_W));
      mask = DATA_W'(lane_mask(MAX_W'(NL'(get_slice(MAX_BUS'(wr_lane), p, NL))), LANE_W));
      if (wr_en[p] && (widx == idx)) begin
        new_val = (new_val & ~mask) | (wdat & mask);
      end
    end
  end

endmodule

// File: rtl/gp_regs_mp.sv
// Multi-port general-purpose register file with lane strobes, write-to-read
// bypass and a busy-bit scoreboard for long-latency producers.
module gp_regs_mp
  import gp_regs_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int REG_NUM = 16,
  parameter int IDX_W   = DEF_IDX_W,
  parameter int NUM_RD  = 2,
  parameter int NUM_WR  = 2,
  parameter int LANE_W  = DEF_LANE_W,
  parameter int ZERO_R0 = 0,
  localparam int NL     = DATA_W / LANE_W
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_WR-1:0]        wr_en_i,
  input  logic [NUM_WR*IDX_W-1:0]  wr_idx_i,
  input  logic [NUM_WR*DATA_W-1:0] wr_data_i,
  input  logic [NUM_WR*NL-1:0]     wr_lane_i,
  input  logic [NUM_WR-1:0]        wr_rel_i,
  input  logic [NUM_RD-1:0]        rd_en_i,
  input  logic [NUM_RD*IDX_W-1:0]  rd_idx_i,
  output logic [NUM_RD*DATA_W-1:0] rd_data_o,
  output logic [NUM_RD-1:0]        rd_busy_o,
  input  logic                     rsv_en_i,
  input  logic [IDX_W-1:0]         rsv_idx_i,
  output logic [REG_NUM-1:0]       busy_o
);

  logic [DATA_W-1:0]  regs   [REG_NUM];
  logic [DATA_W-1:0]  merged [REG_NUM];
  logic [DATA_W-1:0]  nxt    [REG_NUM];
  logic [REG_NUM-1:0] busy_nxt;
  logic [DATA_W-1:0]  rd_val [NUM_RD];
  logic [NUM_RD-1:0]  rd_bsy;

  // nxt[] is both the stored next value and the bypass source for reads.
  for (genvar r = 0; r < REG_NUM; r++) begin : g_reg
    gp_regs_wmerge #(
      .DATA_W(DATA_W), .IDX_W(IDX_W), .NUM_WR(NUM_WR), .LANE_W(LANE_W)
    ) u_merge (
      .idx    (IDX_W'(r)),
      .old_val(regs[r]),
      .wr_en  (wr_en_i),
      .wr_idx (wr_idx_i),
      .wr_data(wr_data_i),
      .wr_lane(wr_lane_i),
      .new_val(merged[r])
    );
    assign nxt[r] = (ZERO_R0 != 0 && r == 0) ? '0 : merged[r];
  end

  // Release first, then reserve, so a same-cycle reserve wins.
  always_comb begin
    logic [IDX_W-1:0] widx;
    busy_nxt = busy_o;
    widx     = '0;
    for (int p = 0; p < NUM_WR; p++) begin
      widx = IDX_W'(get_slice(MAX_BUS'(wr_idx_i), p, IDX_W));
      if (wr_en_i[p] && wr_rel_i[p] && int'(widx) < REG_NUM) busy_nxt[widx] = 1'b0;
    end
    if (rsv_en_i && int'(rsv_idx_i) < REG_NUM) busy_nxt[rsv_idx_i] = 1'b1;
    if (ZERO_R0 != 0) busy_nxt[0] = 1'b0;
  end

  always_comb begin
    logic [IDX_W-1:0] ridx;
    ridx = '0;
    for (int q = 0; q < NUM_RD; q++) begin
      rd_val[q] = '0;
      rd_bsy[q] = 1'b0;
      ridx      = IDX_W'(get_slice(MAX_BUS'(rd_idx_i), q, IDX_W));
      if (int'(ridx) < REG_NUM) begin
        rd_val[q] = nxt[ridx];
        rd_bsy[q] = busy_nxt[ridx];
      end
    end
  end

  // NOTE: the storage array is cleared by reset, so it maps to flops rather
  // than an inferred RAM; reads straight after reset must return zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < REG_NUM; r++) regs[r] <= '0;
    end else begin
      for (int r = 0; r < REG_NUM; r++) regs[r] <= nxt[r];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_o    <= '0;
      rd_data_o <= '0;
      rd_busy_o <= '0;
    end else begin
      busy_o <= busy_nxt;
      for (int q = 0; q < NUM_RD; q++) begin
        if (rd_en_i[q]) begin
          rd_data_o[q*DATA_W +: DATA_W] <= rd_val[q];
          rd_busy_o[q]                  <= rd_bsy[q];
        end
      end
    end
  end

endmodule

// File: tb/tb_gp_regs_mp.sv
// Self-checking bench for gp_regs_mp: table-driven vectors through a scoreboard
// queue, plus hand sequences for register-0 hardwiring and asynchronous reset.
module tb_gp_regs_mp;

  localparam int DW = 32;
  localparam int IW = 4;
  localparam int RN = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [1:0]    wr_en, wr_rel, rd_en;
  logic [7:0]    wr_idx, rd_idx;
  logic [63:0]   wr_data;
  logic [3:0]    wr_lane;
  logic          rsv_en;
  logic [IW-1:0] rsv_idx;

  logic [63:0]   rd_data, rd_data_z;
  logic [1:0]    rd_busy, rd_busy_z;
  logic [RN-1:0] busy, busy_z;

  gp_regs_mp #(.ZERO_R0(0)) dut (
    .clk(clk), .rst_n(rst_n),
    .wr_en_i(wr_en), .wr_idx_i(wr_idx), .wr_data_i(wr_data), .wr_lane_i(wr_lane),
    .wr_rel_i(wr_rel), .rd_en_i(rd_en), .rd_idx_i(rd_idx),
    .rd_data_o(rd_data), .rd_busy_o(rd_busy),
    .rsv_en_i(rsv_en), .rsv_idx_i(rsv_idx), .busy_o(busy)
  );

  gp_regs_mp #(.ZERO_R0(1)) dut_z (
    .clk(clk), .rst_n(rst_n),
    .wr_en_i(wr_en), .wr_idx_i(wr_idx), .wr_data_i(wr_data), .wr_lane_i(wr_lane),
    .wr_rel_i(wr_rel), .rd_en_i(rd_en), .rd_idx_i(rd_idx),
    .rd_data_o(rd_data_z), .rd_busy_o(rd_busy_z),
    .rsv_en_i(rsv_en), .rsv_idx_i(rsv_idx), .busy_o(busy_z)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [1:0]  wr_en, wr_rel;
    logic [3:0]  wi0, wi1;
    logic [31:0] wd0, wd1;
    logic [1:0]  wl0, wl1;
    logic [1:0]  rd_en;
    logic [3:0]  ri0, ri1;
    logic        rsv_en;
    logic [3:0]  rsv_idx;
    logic [31:0] e0, e1;
    logic [1:0]  ebusy_rd;
    logic [15:0] ebusy;
  } vec_t;

  typedef struct {
    string       name;
    logic [63:0] rd;
    logic [1:0]  rdb;
    logic [15:0] busy;
  } exp_t;

  vec_t vecs[16];
  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t v(input string name, input logic [1:0] en, input logic [1:0] rel,
                             input logic [3:0] wi0, input logic [31:0] wd0, input logic [1:0] wl0,
                             input logic [3:0] wi1, input logic [31:0] wd1, input logic [1:0] wl1,
                             input logic [1:0] rden, input logic [3:0] ri0, input logic [3:0] ri1,
                             input logic rsv, input logic [3:0] ridx,
                             input logic [31:0] e0, input logic [31:0] e1,
                             input logic [1:0] erdb, input logic [15:0] ebusy);
    vec_t t;
    t.name = name; t.wr_en = en; t.wr_rel = rel;
    t.wi0 = wi0; t.wd0 = wd0; t.wl0 = wl0;
    t.wi1 = wi1; t.wd1 = wd1; t.wl1 = wl1;
    t.rd_en = rden; t.ri0 = ri0; t.ri1 = ri1;
    t.rsv_en = rsv; t.rsv_idx = ridx;
    t.e0 = e0; t.e1 = e1; t.ebusy_rd = erdb; t.ebusy = ebusy;
    return t;
  endfunction

  task automatic idle();
    wr_en = '0; wr_rel = '0; wr_idx = '0; wr_data = '0; wr_lane = '0;
    rd_en = '0; rd_idx = '0; rsv_en = 1'b0; rsv_idx = '0;
  endtask

  task automatic apply(input vec_t t);
    wr_en   = t.wr_en;
    wr_rel  = t.wr_rel;
    wr_idx  = {t.wi1, t.wi0};
    wr_data = {t.wd1, t.wd0};
    wr_lane = {t.wl1, t.wl0};
    rd_en   = t.rd_en;
    rd_idx  = {t.ri1, t.ri0};
    rsv_en  = t.rsv_en;
    rsv_idx = t.rsv_idx;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    //          name            en     rel    wi0 wd0            wl0    wi1 wd1            wl1    rden   ri0 ri1 rsv   ridx  e0             e1             erdb   ebusy
    vecs[0]  = v("rst_rd",      2'b00, 2'b00, 0, 32'h0,          2'b00, 0, 32'h0,          2'b00, 2'b11, 5,  6,  1'b0, 0,    32'h0,         32'h0,         2'b00, 16'h0000);
    vecs[1]  = v("wr_r5",       2'b01, 2'b00, 5, 32'h0000_0101,  2'b11, 0, 32'h0,          2'b00, 2'b00, 0,  0,  1'b0, 0,    32'h0,         32'h0,         2'b00, 16'h0000);
    vecs[2]  = v("rd_r5",       2'b00, 2'b00, 0, 32'h0,          2'b00, 0, 32'h0,          2'b00, 2'b11, 5,  6,  1'b0, 0,    32'h0000_0101, 32'h0,         2'b00, 16'h0000);
    vecs[3]  = v("wr_r5_hi",    2'b01, 2'b00, 5, 32'hABCD_2222,  2'b10, 0, 32'h0,          2'b00, 2'b00, 0,  0,  1'b0, 0,    32'h0000_0101, 32'h0,         2'b00, 16'h0000);
    vecs[4]  = v("rd_r5_lane",  2'b00, 2'b00, 0, 32'h0,          2'b00, 0, 32'h0,          2'b00, 2'b01, 5,  0,  1'b0, 0,    32'hABCD_0101, 32'h0,         2'b00, 16'h0000);
    vecs[5]  = v("conf_byp",    2'b11, 2'b00, 3, 32'h1111_2222,  2'b11, 3, 32'h3333_4444,  2'b01, 2'b11, 3,  3,  1'b0, 0,    32'h1111_4444, 32'h1111_4444, 2'b00, 16'h0000);
    vecs[6]  = v("conf_store",  2'b00, 2'b00, 0, 32'h0,          2'b00, 0, 32'h0,          2'b00, 2'b11, 3,  5,  1'b0, 0,    32'h1111_4444, 32'hABCD_0101, 2'b00, 16'h0000);
    vecs[7]  = v("byp_r9",      2'b10, 2'b00, 0, 32'h0,          2'b00, 9, 32'h0000_0202,  2'b11, 2'b01, 9,  0,  1'b0, 0,    32'h0000_0202, 32'hABCD_0101, 2'b00, 16'h0000);
    vecs[8]  = v("hold_wr",     2'b01, 2'b00, 9, 32'h0,          2'b11, 0, 32'h0,          2'b00, 2'b00, 0,  0,  1'b0, 0,    32'h0000_0202, 32'hABCD_0101, 2'b00, 16'h0000);
    vecs[9]  = v("hold_idle",   2'b00, 2'b00, 0, 32'h0,          2'b00, 0, 32'h0,          2'b00, 2'b00, 0,  0,  1'b0, 0,    32'h0000_0202, 32'hABCD_0101, 2'b00, 16'h0000);
    vecs[10] = v("rd_r9_zero",  2'b00, 2'b00, 0, 32'h0,          2'b00, 0, 32'h0,          2'b00, 2'b01, 9,  0,  1'b0, 0,    32'h0,         32'hABCD_0101, 2'b00, 16'h0000);
    vecs[11] = v("rsv_r7",      2'b00, 2'b00, 0, 32'h0,          2'b00, 0, 32'h0,          2'b00, 2'b00, 0,  0,  1'b1, 7,    32'h0,         32'hABCD_0101, 2'b00, 16'h0080);
    vecs[12] = v("rsv_rel_r7",  2'b01, 2'b01, 7, 32'h0000_0007,  2'b11, 0, 32'h0,          2'b00, 2'b10, 0,  7,  1'b1, 7,    32'h0,         32'h0000_0007, 2'b10, 16'h0080);
    vecs[13] = v("rel_r7",      2'b01, 2'b01, 7, 32'h0,          2'b00, 0, 32'h0,          2'b00, 2'b01, 7,  0,  1'b0, 0,    32'h0000_0007, 32'h0000_0007, 2'b10, 16'h0000);
    vecs[14] = v("lane_prio",   2'b11, 2'b00, 2, 32'hAAAA_BBBB,  2'b01, 2, 32'hCCCC_DDDD,  2'b01, 2'b01, 2,  0,  1'b1, 2,    32'h0000_DDDD, 32'h0000_0007, 2'b11, 16'h0004);
    vecs[15] = v("rel_p1",      2'b10, 2'b10, 0, 32'h0,          2'b00, 2, 32'h0,          2'b00, 2'b11, 2,  2,  1'b0, 0,    32'h0000_DDDD, 32'h0000_DDDD, 2'b00, 16'h0000);

    // Asynchronous reset before any clock edge.
    idle();
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    check("reset_rd_data",   rd_data,   64'h0);
    check("reset_rd_busy",   rd_busy,   64'h0);
    check("reset_busy",      busy,      64'h0);
    check("reset_z_rd_data", rd_data_z, 64'h0);
    check("reset_z_busy",    busy_z,    64'h0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      apply(vecs[i]);
      e.name = vecs[i].name;
      e.rd   = {vecs[i].e1, vecs[i].e0};
      e.rdb  = vecs[i].ebusy_rd;
      e.busy = vecs[i].ebusy;
      sb.push_back(e);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      check({e.name, "_rd_data"}, rd_data, e.rd);
      check({e.name, "_rd_busy"}, rd_busy, e.rdb);
      check({e.name, "_busy"},    busy,    e.busy);
    end

    // Register 0 hardwiring: write all-ones and reserve r0, reading it the same cycle.
    @(negedge clk);
    idle();
    wr_en = 2'b01; wr_idx = 8'h00; wr_data = {32'h0, 32'hFFFF_FFFF}; wr_lane = 4'b0011;
    rsv_en = 1'b1; rsv_idx = 4'd0;
    rd_en = 2'b01; rd_idx = 8'h00;
    @(posedge clk);
    #1;
    check("z_r0_byp_data", rd_data_z[31:0], 64'h0);
    check("z_r0_byp_busy", rd_busy_z[0],    64'h0);
    check("z_busy_vec",    busy_z,          64'h0);
    check("r0_byp_data",   rd_data[31:0],   64'hFFFF_FFFF);
    check("r0_busy",       busy,            64'h0001);
    @(negedge clk);
    idle();
    rd_en = 2'b01; rd_idx = 8'h00;
    @(posedge clk);
    #1;
    check("z_r0_stored", rd_data_z[31:0], 64'h0);
    check("r0_stored",   rd_data[31:0],   64'hFFFF_FFFF);

    // Reset mid-sequence with a write pending: outputs clear without an edge.
    @(negedge clk);
    idle();
    wr_en = 2'b01; wr_idx = 8'h05; wr_data = {32'h0, 32'h1234_5678}; wr_lane = 4'b0011;
    #2 rst_n = 1'b0;
    #1;
    check("midrst_rd_data", rd_data, 64'h0);
    check("midrst_rd_busy", rd_busy, 64'h0);
    check("midrst_busy",    busy,    64'h0);
    @(posedge clk);
    #1;
    check("midrst_hold", rd_data, 64'h0);
    @(negedge clk);
    idle();
    rst_n = 1'b1;
    rd_en = 2'b11; rd_idx = {4'd3, 4'd5};
    @(posedge clk);
    #1;
    check("post_rst_r5_r3", rd_data, 64'h0);
    check("post_rst_busy",  busy,    64'h0);
    check("sb_drained",     sb.size(), 64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
